// File: rtl/vga_clk_generator.sv
// rtl/vga_clk_generator.sv - VGA raster timing generator: pixel/line counters, syncs, blank and strobes
module vga_clk_generator #(
    parameter bit HPOL       = 1'b1,
    parameter bit VPOL       = 1'b1,
    parameter int FRAME_RATE = 85,
    parameter int HACTIVE    = 640,
    parameter int HFP        = 16,
    parameter int HSLEN      = 96,
    parameter int HBP        = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP        = 10,
    parameter int VSLEN      = 2,
    parameter int VBP        = 33,
    parameter int CW         = 11
) (
    input  logic          pclk,
    input  logic          reset,
    output logic [CW-1:0] out_hcnt,
    output logic [CW-1:0] out_vcnt,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_blank,
    output logic          out_hcycle,
    output logic          out_vcycle
);

    localparam int HTOTAL = HACTIVE + HFP + HSLEN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSLEN + VBP;

    // Thresholds carry one extra bit so a sync window ending exactly at
    // 2^CW (zero back porch, full-width total) does not wrap to zero.
    localparam logic [CW:0]   H_ACT_END = (CW+1)'(HACTIVE);
    localparam logic [CW:0]   HS_START  = (CW+1)'(HACTIVE + HFP);
    localparam logic [CW:0]   HS_END    = (CW+1)'(HACTIVE + HFP + HSLEN);
    localparam logic [CW:0]   V_ACT_END = (CW+1)'(VACTIVE);
    localparam logic [CW:0]   VS_START  = (CW+1)'(VACTIVE + VFP);
    localparam logic [CW:0]   VS_END    = (CW+1)'(VACTIVE + VFP + VSLEN);
    localparam logic [CW-1:0] H_LAST    = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(VTOTAL - 1);

    // Reject geometries the counters cannot represent at elaboration time.
    if (HTOTAL > (1 << CW) || VTOTAL > (1 << CW)) begin : g_bad_width
        $error("vga_clk_generator: HTOTAL/VTOTAL exceed counter width CW");
    end
    if (FRAME_RATE <= 0 || HACTIVE <= 0 || VACTIVE <= 0) begin : g_bad_geom
        $error("vga_clk_generator: FRAME_RATE, HACTIVE and VACTIVE must be positive");
    end

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          line_end;
    logic [CW:0]   hx, vx;

    // Next-count logic: column wraps at the line end, line advances only then.
    always_comb begin
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        line_end = (hcnt_q == H_LAST);
        if (line_end) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + CW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + CW'(1);
        end
    end

    // Counter registers; reset parks the raster at the top-left pixel.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Zero-latency decode so every output lines up with the counters it came from.
    always_comb begin
        hx         = {1'b0, hcnt_q};
        vx         = {1'b0, vcnt_q};
        out_hcnt   = hcnt_q;
        out_vcnt   = vcnt_q;
        out_hsync  = ((hx >= HS_START) && (hx < HS_END)) ? HPOL : ~HPOL;
        out_vsync  = ((vx >= VS_START) && (vx < VS_END)) ? VPOL : ~VPOL;
        out_blank  = (hx >= H_ACT_END) || (vx >= V_ACT_END);
        out_hcycle = line_end;
        out_vcycle = line_end && (vcnt_q == V_LAST);
    end

endmodule

// File: tb/tb_vga_clk_generator.sv
// tb/tb_vga_clk_generator.sv - randomized-reset bench comparing four geometries against a position model
module tb_vga_clk_generator;

    logic pclk = 1'b0;
    logic reset = 1'b1;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        hc;
        logic        vc;
    } exp_t;

    // Default geometry, positive syncs
    logic [10:0] d_h, d_v;
    logic d_hs, d_vs, d_bl, d_hc, d_vc;
    vga_clk_generator u_def (
        .pclk(pclk), .reset(reset), .out_hcnt(d_h), .out_vcnt(d_v),
        .out_hsync(d_hs), .out_vsync(d_vs), .out_blank(d_bl),
        .out_hcycle(d_hc), .out_vcycle(d_vc)
    );

    // Default geometry, negative syncs
    logic [10:0] n_h, n_v;
    logic n_hs, n_vs, n_bl, n_hc, n_vc;
    vga_clk_generator #(.HPOL(1'b0), .VPOL(1'b0)) u_neg (
        .pclk(pclk), .reset(reset), .out_hcnt(n_h), .out_vcnt(n_v),
        .out_hsync(n_hs), .out_vsync(n_vs), .out_blank(n_bl),
        .out_hcycle(n_hc), .out_vcycle(n_vc)
    );

    // Small alternate geometry: 14 x 7
    logic [3:0] a_h, a_v;
    logic a_hs, a_vs, a_bl, a_hc, a_vc;
    vga_clk_generator #(
        .HACTIVE(8), .HFP(2), .HSLEN(3), .HBP(1),
        .VACTIVE(4), .VFP(1), .VSLEN(1), .VBP(1), .CW(4)
    ) u_alt (
        .pclk(pclk), .reset(reset), .out_hcnt(a_h), .out_vcnt(a_v),
        .out_hsync(a_hs), .out_vsync(a_vs), .out_blank(a_bl),
        .out_hcycle(a_hc), .out_vcycle(a_vc)
    );

    // Edge geometry: HTOTAL = 32 = 2^CW, hsync window ends at 32, negative syncs
    logic [4:0] e_h, e_v;
    logic e_hs, e_vs, e_bl, e_hc, e_vc;
    vga_clk_generator #(
        .HPOL(1'b0), .VPOL(1'b0),
        .HACTIVE(20), .HFP(4), .HSLEN(8), .HBP(0),
        .VACTIVE(10), .VFP(2), .VSLEN(3), .VBP(1), .CW(5)
    ) u_edge (
        .pclk(pclk), .reset(reset), .out_hcnt(e_h), .out_vcnt(e_v),
        .out_hsync(e_hs), .out_vsync(e_vs), .out_blank(e_bl),
        .out_hcycle(e_hc), .out_vcycle(e_vc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raster position is just elapsed pixels since reset folded into line/frame.
    function automatic exp_t ref_model(input longint t,
                                       input int ha, input int hf, input int hs, input int hb,
                                       input int va, input int vf, input int vs, input int vb,
                                       input bit hp, input bit vp);
        exp_t e;
        int   ht, vt, h, v;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        h    = int'(t % ht);
        v    = int'((t / ht) % vt);
        e.h  = 16'(h);
        e.v  = 16'(v);
        e.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        e.vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        e.bl = (h >= ha) || (v >= va);
        e.hc = (h == ht - 1);
        e.vc = (h == ht - 1) && (v == vt - 1);
        return e;
    endfunction

    task automatic check_all(input string nm, input exp_t e,
                             input logic [15:0] h, input logic [15:0] v,
                             input logic hs, input logic vs, input logic bl,
                             input logic hc, input logic vc);
        check({nm, ".hcnt"},   32'(h),  32'(e.h));
        check({nm, ".vcnt"},   32'(v),  32'(e.v));
        check({nm, ".hsync"},  32'(hs), 32'(e.hs));
        check({nm, ".vsync"},  32'(vs), 32'(e.vs));
        check({nm, ".blank"},  32'(bl), 32'(e.bl));
        check({nm, ".hcycle"}, 32'(hc), 32'(e.hc));
        check({nm, ".vcycle"}, 32'(vc), 32'(e.vc));
    endtask

    initial begin
        longint t = 0;
        int     rst_left = 5;
        bit     was_reset = 1'b1;
        longint alt_prev_vc = -1;
        int     d_hs_cnt = 0;
        int     a_hs_cnt = 0;
        int     e_vs_cnt = 0;
        exp_t   ed, en, ea, ee;

        reset = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(negedge pclk);
            ed = ref_model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1);
            en = ref_model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            ea = ref_model(t, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1);
            ee = ref_model(t, 20, 4, 8, 0, 10, 2, 3, 1, 1'b0, 1'b0);
            check_all("def",  ed, 16'(d_h), 16'(d_v), d_hs, d_vs, d_bl, d_hc, d_vc);
            check_all("neg",  en, 16'(n_h), 16'(n_v), n_hs, n_vs, n_bl, n_hc, n_vc);
            check_all("alt",  ea, 16'(a_h), 16'(a_v), a_hs, a_vs, a_bl, a_hc, a_vc);
            check_all("edge", ee, 16'(e_h), 16'(e_v), e_hs, e_vs, e_bl, e_hc, e_vc);

            if (reset) begin
                check("rst.def_hcnt",  32'(d_h),  0);
                check("rst.def_vcnt",  32'(d_v),  0);
                check("rst.def_blank", 32'(d_bl), 0);
                check("rst.def_hsync", 32'(d_hs), 0);
                check("rst.def_vsync", 32'(d_vs), 0);
                check("rst.neg_hsync", 32'(n_hs), 1);
                check("rst.neg_vsync", 32'(n_vs), 1);
                check("rst.def_hcyc",  32'(d_hc), 0);
                check("rst.def_vcyc",  32'(d_vc), 0);
            end else if (was_reset) begin
                check("release.def_hcnt", 32'(d_h), 1);
                check("release.alt_hcnt", 32'(a_h), 1);
            end
            was_reset = reset;

            // hsync pulse width per completed line
            if (ed.h == 0) d_hs_cnt = 0;
            if (d_hs) d_hs_cnt++;
            if (ed.h == 799) check("def.hsync_width", d_hs_cnt, 96);
            if (ea.h == 0) a_hs_cnt = 0;
            if (a_hs) a_hs_cnt++;
            if (ea.h == 13) check("alt.hsync_width", a_hs_cnt, 3);

            // vsync asserted cycles per frame on the 32-wide geometry (active low)
            if (ee.h == 0 && ee.v == 0) e_vs_cnt = 0;
            if (!e_vs) e_vs_cnt++;
            if (ee.vc) check("edge.vsync_cycles", e_vs_cnt, 3 * 32);

            // Frame period between consecutive vcycle strobes
            if (a_vc) begin
                if (alt_prev_vc >= 0) check("alt.frame_period", 32'(t - alt_prev_vc), 98);
                alt_prev_vc = t;
            end

            // Reset schedule: power-up, one forced mid-frame hit, rare random hits
            if (rst_left > 0) rst_left--;
            if (rst_left == 0 && (cyc == 12345 || $urandom_range(0, 2999) == 0))
                rst_left = 1 + $urandom_range(0, 5);
            reset = (rst_left > 0);
            if (reset) begin
                t = 0;
                alt_prev_vc = -1;
            end

            @(posedge pclk);
            if (!reset) t++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
